// File: rtl/btn_pkg.sv
// Shared definitions for the button front end: decoder state encoding and
// default timing constants for a 25 MHz system clock.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_t;

    // 1 s hold before long_press, 200 ms between auto-repeat pulses.
    localparam int unsigned LONG_CNT_1S      = 25_000_000;
    localparam int unsigned REPEAT_CNT_200MS = 5_000_000;

endpackage

// File: rtl/button_event_decoder_edge_detect.sv
// Polarity normalisation and edge detection for one synchronous level input.
// Reusable for switch inputs as well as buttons.
module edge_detect #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic act;
    logic act_prev;

    assign act = ACTIVE_LOW ? ~level : level;

    // Previous active level; resets to inactive so a button held through
    // reset produces a fresh rise on the first clock.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) act_prev <= 1'b0;
        else        act_prev <= act;
    end

    assign rise = act & ~act_prev;
    assign fall = ~act & act_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press / release / short /
// long / auto-repeat pulses plus a registered "held" level.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_CNT   = LONG_CNT_1S,
    parameter int unsigned REPEAT_CNT = REPEAT_CNT_200MS,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter int unsigned CNT_W      = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    input  logic en,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    logic             rise;
    logic             fall;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, short_d, long_d, repeat_d;

    edge_detect #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .level(btn_db),
        .rise (rise),
        .fall (fall)
    );

    // State, hold counter and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            short_press   <= short_d;
            long_press    <= long_d;
            repeat_pulse  <= repeat_d;
            held          <= (state_d != IDLE);
        end
    end

    // Next-state, counter and pulse decode; release takes priority over any
    // threshold hit in the same cycle, and en low silently returns to IDLE.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        short_d   = 1'b1;
                    end else if (cnt_q == LONG_LAST) begin
                        state_d = LONG_HELD;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (fall) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else if (!REPEAT_EN) begin
                        cnt_d = '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: directed scenarios plus random hold patterns, compared
// cycle by cycle against a press-age reference model. Two instances share the
// stimulus, one with auto-repeat enabled and one without.
module tb_button_event_decoder;

    localparam int LONG   = 10;
    localparam int REP    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_db;
    logic en;

    logic press_a, release_a, short_a, long_a, repeat_a, held_a;
    logic press_b, release_b, short_b, long_b, repeat_b, held_b;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: index 0 = repeat enabled, 1 = repeat disabled.
    bit         m_prev;
    bit         m_acc [2];
    int         m_age [2];
    logic [5:0] exp_v [2];

    always #5 clk = ~clk;

    button_event_decoder #(
        .ACTIVE_LOW(1'b1), .LONG_CNT(LONG), .REPEAT_CNT(REP),
        .REPEAT_EN(1'b1), .CNT_W(8)
    ) dut_rep (
        .clk(clk), .rst_n(rst_n), .btn_db(btn_db), .en(en),
        .press_pulse(press_a), .release_pulse(release_a), .short_press(short_a),
        .long_press(long_a), .repeat_pulse(repeat_a), .held(held_a)
    );

    button_event_decoder #(
        .ACTIVE_LOW(1'b1), .LONG_CNT(LONG), .REPEAT_CNT(REP),
        .REPEAT_EN(1'b0), .CNT_W(8)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .btn_db(btn_db), .en(en),
        .press_pulse(press_b), .release_pulse(release_b), .short_press(short_b),
        .long_press(long_b), .repeat_pulse(repeat_b), .held(held_b)
    );

    // Bit order: press, release, short, long, repeat, held.
    wire [5:0] obs_a = {press_a, release_a, short_a, long_a, repeat_a, held_a};
    wire [5:0] obs_b = {press_b, release_b, short_b, long_b, repeat_b, held_b};

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s t=%0t got=%b want=%b (press,rel,short,long,rep,held)",
                     tag, $time, obs, want);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_acc[d] = 1'b0;
            m_age[d] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    // A press is tracked by its age in edges; thresholds are plain arithmetic.
    task automatic model_step();
        bit act, rise, fall;
        act  = ~btn_db;
        rise = act & ~m_prev;
        fall = ~act & m_prev;
        for (int d = 0; d < 2; d++) begin
            exp_v[d] = '0;
            if (!m_acc[d]) begin
                if (en && rise) begin
                    m_acc[d]    = 1'b1;
                    m_age[d]    = 0;
                    exp_v[d][5] = 1'b1;
                end
            end else begin
                m_age[d]++;
                if (!en) begin
                    m_acc[d] = 1'b0;
                end else if (fall) begin
                    m_acc[d]    = 1'b0;
                    exp_v[d][4] = 1'b1;
                    if (m_age[d] <= LONG) exp_v[d][3] = 1'b1;
                end else if (m_age[d] == LONG) begin
                    exp_v[d][2] = 1'b1;
                end else if (d == 0 && m_age[d] > LONG && ((m_age[d] - LONG) % REP) == 0) begin
                    exp_v[d][1] = 1'b1;
                end
            end
            exp_v[d][0] = m_acc[d];
        end
        m_prev = act;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, "/rep"},   obs_a, exp_v[0]);
        check({tag, "/norep"}, obs_b, exp_v[1]);
    endtask

    task automatic hold(input logic lvl, input int n, input string tag);
        btn_db = lvl;
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_db = 1'b1;
        en     = 1'b1;
        model_reset();
        #2;
        check("reset/rep",   obs_a, 6'b0);
        check("reset/norep", obs_b, 6'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        hold(1'b1, 3, "idle");

        // Short press: 5 cycles low.
        hold(1'b0, 5, "short");
        hold(1'b1, 3, "short_rel");

        // Long press with repeats.
        hold(1'b0, 25, "long");
        hold(1'b1, 3, "long_rel");

        // Release exactly at the long threshold.
        hold(1'b0, LONG, "thresh");
        hold(1'b1, 3, "thresh_rel");

        // Enable gating: press while disabled, enable while held, then a fresh press.
        en = 1'b0;
        hold(1'b0, 5, "en_off");
        en = 1'b1;
        hold(1'b0, 15, "en_on_held");
        hold(1'b1, 2, "en_rel");
        hold(1'b0, 3, "en_press");
        hold(1'b1, 2, "en_press_rel");

        // Enable dropped while in long hold.
        hold(1'b0, 12, "long_en");
        en = 1'b0;
        hold(1'b0, 10, "long_en_off");
        en = 1'b1;
        hold(1'b1, 2, "long_en_rel");

        // Asynchronous reset mid-hold, released with the button still pressed.
        hold(1'b0, 6, "pre_rst");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_now/rep",   obs_a, 6'b0);
        check("rst_now/norep", obs_b, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold/rep",   obs_a, 6'b0);
        check("rst_hold/norep", obs_b, 6'b0);
        rst_n = 1'b1;
        hold(1'b0, 14, "post_rst");
        hold(1'b1, 3, "post_rst_rel");

        // Random hold patterns with occasional enable drops.
        for (int s = 0; s < 60; s++) begin
            en = ($urandom_range(0, 9) != 0);
            hold(s[0], $urandom_range(1, 30), "rand");
        end
        en = 1'b1;
        hold(1'b1, 3, "tail");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
